fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one FIFO write port; legal values are 2 to 8.
REQ-002 Parameter DATA_WIDTH, default 8: width of the FIFO data word.
REQ-003 Parameter MAX_BURST, default 4: maximum beats per grant; legal values are 1 to 16.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 req  input  N_REQ  per-requester write request, held high while the requester has data.
REQ-007 req_data  input  N_REQ*DATA_WIDTH  requester i's word on bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 fifo_full  input  1  full flag from the write side of the downstream FIFO.
REQ-009 gnt  output  N_REQ  registered one-hot grant; all-zero when no owner.
REQ-010 ack  output  N_REQ  one-hot beat-accepted strobe; the requester advances its data when ack[i] is high.
REQ-011 fifo_w_en  output  1  FIFO write enable.
REQ-012 fifo_data_in  output  DATA_WIDTH  FIFO write data.
REQ-013 busy  output  1  high while in GRANT.
REQ-014 owner  output  $clog2(N_REQ)  index of the current owner; 0 when idle.

Function
REQ-015 The FSM shall have two states: IDLE and GRANT.
REQ-016 In IDLE with any req bit high, the arbiter shall register gnt as the first set req bit found searching upward from rr_ptr (modulo N_REQ), clear beat_cnt, and enter GRANT on the next edge.
REQ-017 Grant latency shall be exactly 1 cycle: req seen at edge t gives gnt high after edge t, and the first beat is possible in that same cycle.
REQ-018 A beat shall occur in any GRANT cycle where req[owner]=1 and fifo_full=0.
REQ-019 On a beat, fifo_w_en=1, ack[owner]=1 and fifo_data_in=req_data[owner], all combinational in the same cycle.
REQ-020 Outside a beat, fifo_w_en=0 and ack=0, and fifo_data_in shall be held at req_data[owner]; the value of fifo_data_in when not writing is otherwise don't-care.
REQ-021 While fifo_full=1, gnt, owner and beat_cnt shall be held with no beat; a grant has no stall timeout.
REQ-022 beat_cnt shall be 4 bits wide and increment on each beat.
REQ-023 The grant is released, returning to IDLE on the next edge, when either:
- req[owner]=0 (no beat occurs in that cycle), or
- a beat occurs with beat_cnt==MAX_BURST-1.
REQ-024 On release, rr_ptr shall be set to (owner+1) mod N_REQ, wrapping from N_REQ-1 to 0.
REQ-025 Every release shall be followed by exactly one IDLE cycle with gnt=0 before the next grant, including a re-grant to the same requester.
REQ-026 Requests from non-owners during GRANT shall be ignored until IDLE; a requester's data is never written unless it holds the grant.
REQ-027 fifo_w_en shall never be high while fifo_full is high, and at most one ack bit shall be high in any cycle.

Reset
REQ-028 With rst=0 at a rising edge, the block shall set state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0 and owner=0.
REQ-029 During reset, fifo_w_en, ack and busy shall be 0 from the following cycle onward.
REQ-030 A reset during a burst shall abort it with no further writes; the remaining data is the requester's responsibility.

Structure
REQ-031 Package fifo_arb_pkg shall hold the state enumeration (IDLE, GRANT) and the default values of N_REQ, DATA_WIDTH and MAX_BURST.
REQ-032 The round-robin search shall be a separate combinational sub-module, rr_pick, with inputs req and rr_ptr and outputs a one-hot grant and an index.
REQ-033 The FSM, counters and data multiplexer shall reside in fifo_write_arbiter.

Verification
REQ-034 Scenario, single requester: req[0] held, req_data[0] stepping 0x10..0x15, fifo_full=0 -> beats 0x10-0x13 on 4 consecutive cycles, then 1 idle cycle, then beats 0x14 and 0x15, then release.
REQ-035 Scenario, fairness: req[0] and req[2] high together after reset -> 4 beats to requester 0, idle cycle, 4 beats to requester 2, idle cycle, then requester 0 again.
REQ-036 Scenario, backpressure: fifo_full=1 for 3 cycles after the 2nd beat -> fifo_w_en=0 and ack=0 for 3 cycles, gnt held, still exactly 4 beats in total.
REQ-037 Scenario, early drop: the requester drops req after 2 beats -> release, 1 idle cycle, rr_ptr=owner+1.
REQ-038 Scenario, wrap: owner=3 releases with req[1] and req[3] high -> next grant goes to requester 1.
REQ-039 Scenario, mid-burst reset: rst=0 during the 2nd beat -> gnt=0 and fifo_w_en=0 from the next cycle; after rst=1 the first grant follows rr_ptr=0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and parameter defaults for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ_DEFAULT      = 4;
    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int MAX_BURST_DEFAULT  = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin search: first set req bit at or above rr_ptr, wrapping modulo N_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick_gnt,
    output logic [IDX_W-1:0] pick_idx,
    output logic             found
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        pick_gnt = '0;
        pick_idx = '0;
        found    = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) begin
                sum = sum - (IDX_W+1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found          = 1'b1;
                pick_gnt[cand] = 1'b1;
                pick_idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ requesters,
// with bursts of up to MAX_BURST beats per grant.
//   state | meaning
//   IDLE  | no owner; picks next requester from rr_ptr
//   GRANT | owner writes a beat whenever it requests and the FIFO is not full
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int MAX_BURST  = MAX_BURST_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic                          fifo_full,
    output logic [N_REQ-1:0]              gnt,
    output logic [N_REQ-1:0]              ack,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          busy,
    output logic [$clog2(N_REQ)-1:0]      owner
);

    localparam int               IDX_W     = $clog2(N_REQ);
    localparam logic [3:0]       LAST_BEAT = 4'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt_q, gnt_nxt;
    logic [IDX_W-1:0] owner_q, owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [3:0]       beat_cnt, beat_cnt_nxt;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             owner_req;
    logic             beat;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .pick_gnt (pick_gnt),
        .pick_idx (pick_idx),
        .found    (pick_found)
    );

    // gnt_q is all-zero outside GRANT, so this is req[owner] only while granted.
    assign owner_req = |(req & gnt_q);
    assign beat      = (state == GRANT) && owner_req && !fifo_full;

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt_q;
        owner_nxt    = owner_q;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = GRANT;
                    gnt_nxt      = pick_gnt;
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!owner_req || (beat && beat_cnt == LAST_BEAT)) begin
                    state_nxt    = IDLE;
                    gnt_nxt      = '0;
                    owner_nxt    = '0;
                    beat_cnt_nxt = '0;
                    rr_ptr_nxt   = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                end else if (beat) begin
                    beat_cnt_nxt = beat_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt_q    <= gnt_nxt;
            owner_q  <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        fifo_data_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ack       = beat ? gnt_q : '0;
    assign fifo_w_en = beat;
    assign busy      = (state == GRANT);
    assign gnt       = gnt_q;
    assign owner     = owner_q;

endmodule
